// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - clipped rectangle fill engine with CPU write pass-through
module rect_fill_engine #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [8:0]        cfg_x,
    input  logic [7:0]        cfg_y,
    input  logic [8:0]        cfg_w,
    input  logic [7:0]        cfg_h,
    input  logic [11:0]       cfg_color,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              busy,
    output logic              done,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [9:0]  FB_W10 = 10'(FB_W);
    localparam logic [8:0]  FB_H9  = 9'(FB_H);
    localparam logic [16:0] FB_W17 = 17'(FB_W);

    state_t             state_q, state_d;
    logic [8:0]         x0_q, x0_d;
    logic [7:0]         y0_q, y0_d;
    logic [8:0]         w_q, w_d;
    logic [7:0]         h_q, h_d;
    logic [11:0]        color_q, color_d;
    logic [9:0]         x_end_q, x_end_d;
    logic [8:0]         y_end_q, y_end_d;
    logic [8:0]         cur_x_q, cur_x_d;
    logic [7:0]         cur_y_q, cur_y_d;
    logic [16:0]        row_base_q, row_base_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic [9:0]         x_sum;
    logic [8:0]         y_sum;
    logic [16:0]        lin;
    logic               fill_issue;
    logic               empty_rect;

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        x_end_d     = x_end_q;
        y_end_d     = y_end_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        row_base_d  = row_base_q;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        fill_issue  = 1'b0;

        x_sum      = {1'b0, x0_q} + {1'b0, w_q};
        y_sum      = {1'b0, y0_q} + {1'b0, h_q};
        lin        = row_base_q + {8'b0, cur_x_q};
        empty_rect = (w_q == 9'd0) || (h_q == 8'd0) ||
                     ({1'b0, x0_q} >= FB_W10) || ({1'b0, y0_q} >= FB_H9);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = cfg_x;
                    y0_d    = cfg_y;
                    w_d     = cfg_w;
                    h_d     = cfg_h;
                    color_d = cfg_color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                x_end_d = (x_sum > FB_W10) ? FB_W10 : x_sum;
                y_end_d = (y_sum > FB_H9) ? FB_H9 : y_sum;
                if (empty_rect) begin
                    state_d = S_DONE;
                end else begin
                    cur_x_d    = x0_q;
                    cur_y_d    = y0_q;
                    // y*320 as y*256 + y*64
                    row_base_d = ({9'b0, y0_q} << 8) + ({9'b0, y0_q} << 6);
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (!cpu_write) begin
                    fill_issue = 1'b1;
                    if (({1'b0, cur_x_q} + 10'd1) == x_end_q) begin
                        cur_x_d    = x0_q;
                        cur_y_d    = cur_y_q + 8'd1;
                        row_base_d = row_base_q + FB_W17;
                        if (({1'b0, cur_y_q} + 9'd1) == y_end_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cur_x_d = cur_x_q + 9'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // CPU writes win; fill pixels past the addressable range are consumed silently
        if (cpu_write) begin
            mem_write_d = 1'b1;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
        end else if (fill_issue && ((lin >> ADDR_W) == 17'd0)) begin
            mem_write_d = 1'b1;
            mem_addr_d  = lin[ADDR_W-1:0];
            mem_wdata_d = {20'h0, color_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            row_base_q  <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            x_end_q     <= x_end_d;
            y_end_q     <= y_end_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            row_base_q  <= row_base_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = (state_q == S_SETUP) || (state_q == S_FILL);
    assign done      = (state_q == S_DONE);
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb/tb_rect_fill_engine.sv - scoreboard bench for rect_fill_engine
module tb_rect_fill_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  cfg_x = '0;
    logic [7:0]  cfg_y = '0;
    logic [8:0]  cfg_w = '0;
    logic [7:0]  cfg_h = '0;
    logic [11:0] cfg_color = '0;
    logic        cpu_write = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        busy, done, mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;

    rect_fill_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .cfg_color (cfg_color),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .busy      (busy),
        .done      (done),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          x, y, w, h;
        logic [11:0] c;
        int          pix;
        int          wr;
    } vec_t;

    vec_t        vecs[9];
    logic [47:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          first_wr = -1;
    int          last_wr = -1;

    always @(negedge clk) begin
        logic [47:0] exp_w;
        if (done === 1'b1) done_cnt++;
        if (mem_write === 1'b1) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({mem_addr, mem_wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_wdata, exp_w[47:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, $signed(act), $signed(exp_v));
        end
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        wr_cnt   = 0;
        done_cnt = 0;
        first_wr = -1;
        last_wr  = -1;
    endtask

    task automatic drive_start(input int x, input int y, input int w, input int h,
                               input logic [11:0] c, output int n);
        @(posedge clk);
        #1;
        cfg_x     = 9'(x);
        cfg_y     = 8'(y);
        cfg_w     = 9'(w);
        cfg_h     = 8'(h);
        cfg_color = c;
        start     = 1'b1;
        n         = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int exp_cyc, input string nm);
        int got = -1;
        bit busy_bad = 1'b0;
        for (int k = 0; k < 600 && got < 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = cyc;
                if (busy !== 1'b0) busy_bad = 1'b1;
            end else if (cyc > n && busy !== 1'b1) begin
                busy_bad = 1'b1;
            end
        end
        chk({nm, "_done_cycle"}, 64'(got - n), 64'(exp_cyc - n));
        chk({nm, "_busy_window"}, 64'(busy_bad), 64'd0);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, 64'(done), 64'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int n;
        int lin;
        for (int yy = v.y; yy < v.y + v.h && yy < 240; yy++) begin
            for (int xx = v.x; xx < v.x + v.w && xx < 320; xx++) begin
                lin = yy * 320 + xx;
                if (lin < 65536) sb.push_back({16'(lin), 20'h0, v.c});
            end
        end
        clear_stats();
        drive_start(v.x, v.y, v.w, v.h, v.c, n);
        wait_done(n, n + 2 + v.pix, nm);
        chk({nm, "_write_count"}, 64'(wr_cnt), 64'(v.wr));
        chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
        if (v.wr > 0) chk({nm, "_first_write_cycle"}, 64'(first_wr - n), 64'd3);
        if (v.wr > 0 && v.wr == v.pix) chk({nm, "_last_write_cycle"}, 64'(last_wr - n), 64'(2 + v.pix));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, n2;
        vecs[0] = '{x: 10,  y: 5,   w: 3,   h: 2,   c: 12'hF00, pix: 6,  wr: 6};
        vecs[1] = '{x: 318, y: 238, w: 10,  h: 10,  c: 12'h0F0, pix: 4,  wr: 0};
        vecs[2] = '{x: 5,   y: 0,   w: 0,   h: 4,   c: 12'h00F, pix: 0,  wr: 0};
        vecs[3] = '{x: 320, y: 0,   w: 4,   h: 4,   c: 12'h00F, pix: 0,  wr: 0};
        vecs[4] = '{x: 0,   y: 0,   w: 1,   h: 1,   c: 12'hABC, pix: 1,  wr: 1};
        vecs[5] = '{x: 0,   y: 204, w: 5,   h: 1,   c: 12'h123, pix: 5,  wr: 5};
        vecs[6] = '{x: 250, y: 204, w: 80,  h: 1,   c: 12'h456, pix: 70, wr: 6};
        vecs[7] = '{x: 511, y: 255, w: 511, h: 255, c: 12'h789, pix: 0,  wr: 0};
        vecs[8] = '{x: 300, y: 10,  w: 30,  h: 3,   c: 12'hFFF, pix: 60, wr: 60};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_mem_write", 64'(mem_write), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // CPU writes stall the fill for two cycles after the first pixel
        sb.push_back({16'd1610, 32'h0000_0F00});
        sb.push_back({16'h0042, 32'h0000_0ABC});
        sb.push_back({16'h0042, 32'h0000_0ABC});
        sb.push_back({16'd1611, 32'h0000_0F00});
        sb.push_back({16'd1612, 32'h0000_0F00});
        sb.push_back({16'd1930, 32'h0000_0F00});
        sb.push_back({16'd1931, 32'h0000_0F00});
        sb.push_back({16'd1932, 32'h0000_0F00});
        clear_stats();
        drive_start(10, 5, 3, 2, 12'hF00, n);
        goto_cyc(n + 3);
        cpu_write = 1'b1;
        cpu_addr  = 16'h0042;
        cpu_wdata = 32'h0000_0ABC;
        goto_cyc(n + 5);
        cpu_write = 1'b0;
        wait_done(n, n + 10, "stall");
        chk("stall_write_count", 64'(wr_cnt), 64'd8);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);

        // start while busy must be ignored, cfg changes must not leak in
        for (int i = 0; i < 6; i++)
            sb.push_back({16'(1610 + (i / 3) * 320 + (i % 3)), 32'h0000_0F00});
        clear_stats();
        drive_start(10, 5, 3, 2, 12'hF00, n);
        goto_cyc(n + 3);
        cfg_x = 9'd0; cfg_y = 8'd0; cfg_w = 9'd50; cfg_h = 8'd50; cfg_color = 12'h111;
        start = 1'b1;
        goto_cyc(n + 4);
        start = 1'b0;
        wait_done(n, n + 8, "busy_start");
        goto_cyc(n + 40);
        chk("busy_start_write_count", 64'(wr_cnt), 64'd6);
        chk("busy_start_done_count", 64'(done_cnt), 64'd1);

        // start in the DONE cycle ignored, start in the following IDLE cycle accepted
        sb.push_back({16'd0, 32'h0000_0123});
        sb.push_back({16'd640, 32'h0000_0123});
        clear_stats();
        drive_start(0, 0, 1, 1, 12'h123, n);
        goto_cyc(n + 3);
        chk("done_cycle_pulse", 64'(done), 64'd1);
        cfg_y = 8'd1;
        start = 1'b1;
        goto_cyc(n + 4);
        chk("done_cycle_start_ignored", 64'(busy), 64'd0);
        cfg_y = 8'd2;
        n2    = cyc;
        goto_cyc(n + 5);
        start = 1'b0;
        wait_done(n2, n2 + 3, "idle_restart");
        chk("idle_restart_write_count", 64'(wr_cnt), 64'd2);
        chk("idle_restart_sb_empty", 64'(sb.size()), 64'd0);

        // reset during the third fill write aborts without done
        sb.push_back({16'd1610, 32'h0000_0F00});
        sb.push_back({16'd1611, 32'h0000_0F00});
        sb.push_back({16'd1612, 32'h0000_0F00});
        clear_stats();
        drive_start(10, 5, 3, 2, 12'hF00, n);
        goto_cyc(n + 5);
        reset = 1'b1;
        goto_cyc(n + 6);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_mem_write", 64'(mem_write), 64'd0);
        goto_cyc(n + 20);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_write_count", 64'(wr_cnt), 64'd3);
        chk("abort_sb_empty", 64'(sb.size()), 64'd0);
        run_vec(vecs[0], "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
